front_panel_reset: RTL

Front-panel button conditioner for the Apple I core. It synchronises and debounces the raw RESET and CLEAR SCREEN pushbuttons. RESET produces a stretched active-high warm reset for the 6502/PIA. CLEAR SCREEN produces a request/acknowledge handshake toward the video block. The block runs on the 25 MHz master clock, uses the shared clock enable for all timing, and is held idle by the system reset from the power-on reset generator.

---
 rtl/front_panel_reset.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/front_panel_reset.sv
// ---------------------------------------------------------------------------
// front_panel_reset
//
// Conditions the two Apple I front-panel pushbuttons. Each raw button is
// brought into the clk25 domain through a two-flop synchroniser, then
// debounced against the shared clock enable. The debounced RESET button
// drives a stretched warm reset; the debounced CLEAR SCREEN button drives a
// request/acknowledge handshake toward the video block.
//
// State machines:
//   reset FSM
//     state    | meaning
//     IDLE     | no warm reset in progress
//     HOLD     | warm reset asserted, minimum pulse width running
//     WAIT_REL | minimum width met, waiting for the button to release
//   clear-screen FSM
//     state      | meaning
//     C_IDLE     | no request outstanding
//     C_REQ      | request raised, waiting for the video block ack
//     C_WAIT_REL | acknowledged, waiting for the button to release
//
// Parameters:
//   DEBOUNCE_TICKS - enable ticks an input must disagree with its debounced
//                    level before the level flips (>= 2)
//   MIN_PULSE      - minimum warm reset width in enable ticks (>= 1)
//
// Ports:
//   clk25       in  25 MHz master clock
//   rst         in  synchronous active-high system reset
//   enable      in  clock-enable tick for all debounce/pulse timing
//   reset_btn_n in  raw RESET button, asynchronous, active low
//   cls_btn_n   in  raw CLEAR SCREEN button, asynchronous, active low
//   cls_ack     in  video block acknowledge for cls_req
//   warm_rst    out registered active-high CPU/PIA warm reset
//   cls_req     out registered clear-screen request level
// ---------------------------------------------------------------------------
module front_panel_reset #(
    parameter int unsigned DEBOUNCE_TICKS = 16,
    parameter int unsigned MIN_PULSE      = 32
) (
    input  logic clk25,
    input  logic rst,
    input  logic enable,
    input  logic reset_btn_n,
    input  logic cls_btn_n,
    input  logic cls_ack,
    output logic warm_rst,
    output logic cls_req
);

    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS);
    localparam int unsigned PW = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(MIN_PULSE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } rst_state_t;

    typedef enum logic [1:0] {
        C_IDLE     = 2'd0,
        C_REQ      = 2'd1,
        C_WAIT_REL = 2'd2
    } cls_state_t;

    // Synchronisers: bit 1 is the synchronised level.
    logic [1:0]    rst_sync_q, rst_sync_d;
    logic [1:0]    cls_sync_q, cls_sync_d;

    // Debouncers
    logic          rst_db_q, rst_db_d;
    logic          cls_db_q, cls_db_d;
    logic [DW-1:0] rst_cnt_q, rst_cnt_d;
    logic [DW-1:0] cls_cnt_q, cls_cnt_d;

    // Reset FSM
    rst_state_t    rst_state_q, rst_state_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic          warm_rst_q, warm_rst_d;

    // Clear-screen FSM
    cls_state_t    cls_state_q, cls_state_d;
    logic          cls_req_q, cls_req_d;

    // -----------------------------------------------------------------------
    // Synchronisers run every clk25 cycle, independent of enable.
    // -----------------------------------------------------------------------
    always_comb begin
        rst_sync_d = {rst_sync_q[0], reset_btn_n};
        cls_sync_d = {cls_sync_q[0], cls_btn_n};
    end

    // -----------------------------------------------------------------------
    // Debouncers. Any cycle where the synchronised input agrees with the
    // debounced level restarts the count, so a bounce shorter than
    // DEBOUNCE_TICKS enable ticks never reaches the FSMs.
    // -----------------------------------------------------------------------
    always_comb begin
        rst_db_d  = rst_db_q;
        rst_cnt_d = rst_cnt_q;
        if (rst_sync_q[1] == rst_db_q) begin
            rst_cnt_d = '0;
        end else if (enable) begin
            if (rst_cnt_q == DB_LAST) begin
                rst_db_d  = rst_sync_q[1];
                rst_cnt_d = '0;
            end else begin
                rst_cnt_d = rst_cnt_q + DW'(1);
            end
        end
    end

    always_comb begin
        cls_db_d  = cls_db_q;
        cls_cnt_d = cls_cnt_q;
        if (cls_sync_q[1] == cls_db_q) begin
            cls_cnt_d = '0;
        end else if (enable) begin
            if (cls_cnt_q == DB_LAST) begin
                cls_db_d  = cls_sync_q[1];
                cls_cnt_d = '0;
            end else begin
                cls_cnt_d = cls_cnt_q + DW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Reset FSM. Both exits back to IDLE require the debounced level to be
    // released, so a low debounced level seen in IDLE is always a fresh
    // press and no separate edge detector is needed.
    // -----------------------------------------------------------------------
    always_comb begin
        rst_state_d = rst_state_q;
        pulse_cnt_d = pulse_cnt_q;
        case (rst_state_q)
            IDLE: begin
                if (!rst_db_q) begin
                    rst_state_d = HOLD;
                    pulse_cnt_d = '0;
                end
            end
            HOLD: begin
                if (enable) begin
                    if (pulse_cnt_q == PULSE_LAST) begin
                        pulse_cnt_d = '0;
                        rst_state_d = rst_db_q ? IDLE : WAIT_REL;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + PW'(1);
                    end
                end
            end
            WAIT_REL: begin
                if (rst_db_q) begin
                    rst_state_d = IDLE;
                end
            end
            default: begin
                rst_state_d = IDLE;
                pulse_cnt_d = '0;
            end
        endcase
        // Output flop tracks the next state so warm_rst is glitch-free and
        // changes on the same edge as the state register.
        warm_rst_d = (rst_state_d != IDLE);
    end

    // -----------------------------------------------------------------------
    // Clear-screen FSM. The ack is only looked at in C_REQ, so an ack that
    // coincides with the edge raising the request is not taken.
    // -----------------------------------------------------------------------
    always_comb begin
        cls_state_d = cls_state_q;
        case (cls_state_q)
            C_IDLE: begin
                if (!cls_db_q) begin
                    cls_state_d = C_REQ;
                end
            end
            C_REQ: begin
                if (cls_ack) begin
                    cls_state_d = C_WAIT_REL;
                end
            end
            C_WAIT_REL: begin
                if (cls_db_q) begin
                    cls_state_d = C_IDLE;
                end
            end
            default: begin
                cls_state_d = C_IDLE;
            end
        endcase
        cls_req_d = (cls_state_d == C_REQ);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk25) begin
        if (rst) begin
            rst_sync_q  <= 2'b11;
            cls_sync_q  <= 2'b11;
            rst_db_q    <= 1'b1;
            cls_db_q    <= 1'b1;
            rst_cnt_q   <= '0;
            cls_cnt_q   <= '0;
            rst_state_q <= IDLE;
            pulse_cnt_q <= '0;
            warm_rst_q  <= 1'b0;
            cls_state_q <= C_IDLE;
            cls_req_q   <= 1'b0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            cls_sync_q  <= cls_sync_d;
            rst_db_q    <= rst_db_d;
            cls_db_q    <= cls_db_d;
            rst_cnt_q   <= rst_cnt_d;
            cls_cnt_q   <= cls_cnt_d;
            rst_state_q <= rst_state_d;
            pulse_cnt_q <= pulse_cnt_d;
            warm_rst_q  <= warm_rst_d;
            cls_state_q <= cls_state_d;
            cls_req_q   <= cls_req_d;
        end
    end

    assign warm_rst = warm_rst_q;
    assign cls_req  = cls_req_q;

endmodule
